// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent positive-edge JK flip-flops with asynchronous active-high reset.
// Optional clock enable port ce is present when JK_FF_CE_EN is defined.
module jk_flip_flop #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
`ifdef JK_FF_CE_EN
  input  logic             ce,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic             en;
  logic [WIDTH-1:0] q_next;

`ifdef JK_FF_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  // Characteristic equation: set on J, keep unless K, so J=K=1 toggles.
  assign q_next = (j & ~q) | (~k & q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {WIDTH{RST_VAL}};
    end else if (en) begin
      q <= q_next;
    end
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench for jk_flip_flop: directed steps followed by randomized JK traffic
// compared against a per-bit truth-table model; exercises ce when JK_FF_CE_EN is defined.
module tb_jk_flip_flop;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce_v = 1'b1;

  logic       j1 = 1'b0, k1 = 1'b0, q1, qb1;
  logic [3:0] j4 = '0, k4 = '0, q4, qb4;
  logic [2:0] j3 = '0, k3 = '0, q3, qb3;

  logic [3:0] m1, m4, m3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_flip_flop #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .j(j1), .k(k1),
`ifdef JK_FF_CE_EN
    .ce(ce_v),
`endif
    .q(q1), .q_bar(qb1)
  );

  jk_flip_flop #(.WIDTH(4), .RST_VAL(1'b0)) dut4 (
    .clk(clk), .rst(rst), .j(j4), .k(k4),
`ifdef JK_FF_CE_EN
    .ce(ce_v),
`endif
    .q(q4), .q_bar(qb4)
  );

  jk_flip_flop #(.WIDTH(3), .RST_VAL(1'b1)) dut3 (
    .clk(clk), .rst(rst), .j(j3), .k(k3),
`ifdef JK_FF_CE_EN
    .ce(ce_v),
`endif
    .q(q3), .q_bar(qb3)
  );

  // Reference: apply the JK truth table bit by bit.
  function automatic logic [3:0] jk_model(input logic [3:0] qv, input logic [3:0] jv,
                                          input logic [3:0] kv, input logic en);
    logic [3:0] r;
    r = qv;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        case ({jv[i], kv[i]})
          2'b00:   r[i] = qv[i];
          2'b01:   r[i] = 1'b0;
          2'b10:   r[i] = 1'b1;
          default: r[i] = ~qv[i];
        endcase
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q1"},   {3'b000, q1},  {3'b000, m1[0]});
    chk({tag, "_qb1"},  {3'b000, qb1}, {3'b000, ~m1[0]});
    chk({tag, "_q4"},   q4,            m4);
    chk({tag, "_qb4"},  qb4,           ~m4);
    chk({tag, "_q3"},   {1'b0, q3},    {1'b0, m3[2:0]});
    chk({tag, "_qb3"},  {1'b0, qb3},   {1'b0, ~m3[2:0]});
  endtask

  task automatic reset_models();
    m1 = 4'b0000;
    m4 = 4'b0000;
    m3 = 4'b0111;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    m1 = jk_model(m1, {3'b000, j1}, {3'b000, k1}, ce_v);
    m4 = jk_model(m4, j4, k4, ce_v);
    m3 = jk_model(m3, {1'b0, j3}, {1'b0, k3}, ce_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_models();

    // Asynchronous reset between edges, held across the t=5 edge.
    #2 rst = 1'b1;
    #1;
    check_all("async_rst");
    chk("async_rst_q1_const", {3'b000, q1}, 4'b0000);
    chk("async_rst_qb1_const", {3'b000, qb1}, 4'b0001);
    j1 = 1'b1; k1 = 1'b0; j4 = 4'hF; k4 = 4'h0; j3 = 3'b000; k3 = 3'b111;
    #8;
    check_all("rst_hold");
    #1 rst = 1'b0;
    #1;
    check_all("rst_release");

    // Set / hold / clear on the single-bit instance.
    j4 = '0; k4 = '0; j3 = '0; k3 = '0;
    j1 = 1'b1; k1 = 1'b0;
    edge_step(); check_all("set");
    chk("set_q1_const", {3'b000, q1}, 4'b0001);
    j1 = 1'b0; k1 = 1'b0;
    edge_step(); check_all("hold");
    chk("hold_q1_const", {3'b000, q1}, 4'b0001);
    j1 = 1'b0; k1 = 1'b1;
    edge_step(); check_all("clear");
    chk("clear_qb1_const", {3'b000, qb1}, 4'b0001);

    // Toggle three times from 0: 1, 0, 1.
    j1 = 1'b1; k1 = 1'b1;
    edge_step(); chk("toggle1", {3'b000, q1}, 4'b0001); check_all("toggle1");
    edge_step(); chk("toggle2", {3'b000, q1}, 4'b0000); check_all("toggle2");
    edge_step(); chk("toggle3", {3'b000, q1}, 4'b0001); check_all("toggle3");

    // Reset pulse mid-toggle, then toggling resumes from 0.
    #2 rst = 1'b1;
    #1;
    reset_models();
    check_all("mid_rst");
    chk("mid_rst_q1_const", {3'b000, q1}, 4'b0000);
    #2 rst = 1'b0;
    edge_step(); chk("resume", {3'b000, q1}, 4'b0001); check_all("resume");

    // WIDTH=4 mixed JK from 0011 gives 1001.
    j1 = 1'b0; k1 = 1'b0;
    j4 = 4'b0011; k4 = 4'b1100;
    edge_step(); chk("w4_pre", q4, 4'b0011);
    j4 = 4'b1010; k4 = 4'b0110;
    edge_step(); chk("w4_mix", q4, 4'b1001); chk("w4_mix_bar", qb4, 4'b0110);
    check_all("w4_mix");

`ifdef JK_FF_CE_EN
    j1 = 1'b0; k1 = 1'b1; j4 = '0; k4 = '0;
    edge_step(); chk("ce_prep", {3'b000, q1}, 4'b0000);
    ce_v = 1'b0; j1 = 1'b1; k1 = 1'b0;
    edge_step(); chk("ce_off1", {3'b000, q1}, 4'b0000);
    edge_step(); chk("ce_off2", {3'b000, q1}, 4'b0000);
    ce_v = 1'b1;
    edge_step(); chk("ce_on", {3'b000, q1}, 4'b0001);
    check_all("ce");
`endif

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      j1 = 1'($urandom); k1 = 1'($urandom);
      j4 = 4'($urandom); k4 = 4'($urandom);
      j3 = 3'($urandom); k3 = 3'($urandom);
`ifdef JK_FF_CE_EN
      ce_v = ($urandom_range(0, 3) != 0);
`endif
      edge_step();
      check_all("rand");
      if ($urandom_range(0, 19) == 0) begin
        #1 rst = 1'b1;
        #1;
        reset_models();
        check_all("rand_rst");
        #1 rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
